// File: rtl/mux3_arb_pkg.sv
// mux3_arb_pkg: select encodings, state encoding and index helpers shared by the 3:1 mux arbiter.
package mux3_arb_pkg;
  localparam int N_REQ = 3;
  localparam logic [1:0] SEL_D0   = 2'b00;
  localparam logic [1:0] SEL_D1   = 2'b01;
  localparam logic [1:0] SEL_I2   = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  typedef logic [1:0] idx_t;
  function automatic logic [1:0] sel_of(input idx_t idx);
    return (idx == 2'd2) ? SEL_I2 : (idx == 2'd1) ? SEL_D1 : SEL_D0;
  endfunction
  function automatic logic [N_REQ-1:0] onehot(input idx_t idx);
    return 3'b001 << idx;
  endfunction
  function automatic idx_t next_idx(input idx_t idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction
endpackage

// File: rtl/mux3_arbiter_rr_pick3.sv
// rr_pick3: combinational round-robin pick over three requests, scanning up from ptr with wrap.
module rr_pick3
  import mux3_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic [2:0] mask,
  output logic       found,
  output logic [1:0] winner
);
  logic [2:0] w_elig;
  idx_t       w_p0, w_p1, w_p2;
  always_comb begin
    w_elig = req & ~mask;
    w_p0   = (ptr == 2'd3) ? 2'd0 : ptr;
    w_p1   = next_idx(w_p0);
    w_p2   = next_idx(w_p1);
    found  = |w_elig;
    winner = w_elig[w_p0] ? w_p0 : w_elig[w_p1] ? w_p1 : w_elig[w_p2] ? w_p2 : 2'd0;
  end
endmodule

// File: rtl/mux3_arbiter.sv
// mux3_arbiter: round-robin owner of the cascaded 3:1 mux selects; registers one-hot grant and S1/S0.
// Optional per-owner hold limit compiled in with MUX3_ARB_TIMEOUT_EN.
module mux3_arbiter
  import mux3_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic       sel_s1,
  output logic       sel_s0,
  output logic       busy
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range");
  end
  logic [0:0] r_state;
  idx_t       r_own;
  idx_t       r_ptr;
  logic [2:0] w_mask;
  logic       w_rel, w_tmo, w_arb, w_found;
  idx_t       w_win;
`ifdef MUX3_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
  logic [HW-1:0] r_hold;
  always_comb w_tmo = (r_state == ST_GRANT) && req[r_own] && (r_hold == HOLD_MAX) && |(req & ~w_mask);
`else
  always_comb w_tmo = 1'b0;
`endif
  always_comb begin
    w_mask = (r_state == ST_GRANT) ? onehot(r_own) : 3'b000;
    w_rel  = (r_state == ST_GRANT) && !req[r_own];
    w_arb  = (r_state == ST_IDLE) || w_rel || w_tmo;
  end
  rr_pick3 u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .mask   (w_mask),
    .found  (w_found),
    .winner (w_win)
  );
  // Every output register moves on the same edge so gnt, selects and busy never disagree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_own           <= 2'd0;
      r_ptr           <= 2'd0;
      gnt             <= 3'b000;
      {sel_s1,sel_s0} <= SEL_NONE;
      busy            <= 1'b0;
    end else if (w_arb) begin
      r_state         <= w_found ? ST_GRANT : ST_IDLE;
      r_own           <= w_win;
      r_ptr           <= w_found ? next_idx(w_win) : r_ptr;
      gnt             <= w_found ? onehot(w_win) : 3'b000;
      {sel_s1,sel_s0} <= w_found ? sel_of(w_win) : SEL_NONE;
      busy            <= w_found;
    end
  end
`ifdef MUX3_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || w_arb) r_hold <= '0;
    else if (r_hold != HOLD_MAX) r_hold <= r_hold + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mux3_arbiter.sv
// tb_mux3_arbiter: randomized scoreboard bench against a behavioural round-robin owner model.
module tb_mux3_arbiter;
  localparam int MAX_HOLD = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] gnt;
  logic       sel_s1, sel_s0, busy;
  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] exp_q[$];
  int         m_own = -1, m_ptr = 0, m_hold = 0;
  logic [2:0] prev;

  mux3_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .sel_s1(sel_s1), .sel_s0(sel_s0), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [2:0] r, input int p, input int excl);
    for (int k = 0; k < 3; k++) begin
      int i = (p + k) % 3;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_own = w;
    m_hold = 0;
    if (w >= 0) m_ptr = (w + 1) % 3;
  endtask

  task automatic model(input logic rn, input logic [2:0] r);
    bit others;
    if (!rn) begin
      m_own = -1; m_ptr = 0; m_hold = 0;
    end else if (m_own < 0) grant_to(pick(r, m_ptr, -1));
    else if (!r[m_own]) grant_to(pick(r, m_ptr, m_own));
    else begin
      others = (r & ~(3'b001 << m_own)) != 3'b000;
`ifdef MUX3_ARB_TIMEOUT_EN
      if (m_hold == MAX_HOLD - 1 && others) grant_to(pick(r, m_ptr, m_own));
      else if (m_hold < MAX_HOLD - 1) m_hold++;
`else
      if (others) m_hold = 0;
`endif
    end
  endtask

  function automatic logic [5:0] expected();
    logic [2:0] g;
    g = (m_own < 0) ? 3'b000 : (3'b001 << m_own);
    return {g, m_own == 2, m_own == 1, m_own >= 0};
  endfunction

  task automatic step(input logic rn, input logic [2:0] r);
    @(negedge clk);
    rst_n = rn;
    req = r;
    prev = r;
    model(rn, r);
    exp_q.push_back(expected());
  endtask

  initial forever begin
    logic [5:0] e, a;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gnt, sel_s1, sel_s0, busy};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got gnt=%b s1s0=%b%b busy=%b, want gnt=%b s1s0=%b%b busy=%b",
                 $time, a[5:3], a[2], a[1], a[0], e[5:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    step(0, 3'b111); step(0, 3'b111);
    step(1, 3'b111);
    step(1, 3'b110); step(1, 3'b111);
    step(1, 3'b101); step(1, 3'b111);
    step(1, 3'b011); step(1, 3'b111);
    step(1, 3'b000);
    step(1, 3'b100); step(1, 3'b100);
    step(1, 3'b000);
    step(1, 3'b010); step(1, 3'b101);
    step(0, 3'b101);
    step(1, 3'b110); step(1, 3'b110);
`ifdef MUX3_ARB_TIMEOUT_EN
    step(0, 3'b000);
    repeat (20) step(1, 3'b011);
    step(1, 3'b000);
    repeat (12) step(1, 3'b001);
`endif
    step(1, 3'b000);
    repeat (600) begin
      logic [2:0] r;
      r = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : prev;
      step(($urandom_range(0, 59) != 0), r);
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux3_arbiter.md
# mux3_arbiter

Sequential round-robin arbiter that shares the 3:1 select mux (two cascaded 2:1 stages: first stage picks D0/D1 on S0, second picks first-stage output or I2 on S1) among three requesters. It registers a one-hot grant and drives the mux select lines S1/S0 to match, so exactly one requester's data reaches Out at a time. It sits directly in front of the mux select pins and is the only driver of S1/S0.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles per owner when the timeout feature is compiled in; legal range 2..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req  input  3  request per source; bit 0 = D0, bit 1 = D1, bit 2 = I2; level-sensitive, held high while access is wanted.
- gnt  output  3  registered one-hot grant, or 000.
- sel_s1  output  1  registered mux select S1.
- sel_s0  output  1  registered mux select S0.
- busy  output  1  registered; high when gnt is nonzero.

## Operation
- Select encoding: owner 0 -> S1=0,S0=0; owner 1 -> S1=0,S0=1; owner 2 -> S1=1,S0=0; no owner -> S1=0,S0=0. S1=S0=1 is never driven.
- State: IDLE (gnt=000) and GRANT (gnt one-hot); 2-bit priority pointer ptr (values 0..2).
- Pick rule: scan req starting at index ptr, ascending, wrapping 2->0; first set bit wins.
- IDLE: if req != 000, go to GRANT with the picked owner; ptr <= owner+1 mod 3. Otherwise stay.
- GRANT: while req[owner] stays high, grant holds (subject to timeout). When req[owner] is sampled low, on that same edge re-arbitrate over remaining requests: grant the pick directly (no idle cycle) or go to IDLE if none.
- Request drop of non-owners has no effect. Grant never changes except on release, timeout, or reset.
- gnt, sel_s1, sel_s0 and busy always update on the same edge and are mutually consistent.

## Timing
- Reset: on a clk edge with rst_n=0, gnt=000, sel_s1=0, sel_s0=0, busy=0, ptr=0, hold counter=0, state IDLE. Reset overrides any in-progress grant.
- Latency: req sampled on edge N -> gnt/sel valid after edge N (visible in cycle N+1). One cycle from request to grant.
- Release: req[owner] low sampled at edge N -> new owner or 000 after edge N.
- Simultaneous requests from IDLE: resolved by ptr; after reset, 111 grants owner 0, then 1, then 2 on successive releases.
- Owner drops and reasserts on the same edge (pulse low one cycle): treated as release; it rejoins arbitration at its rotated priority.

## Configuration
- MUX3_ARB_TIMEOUT_EN defined: hold counter, width clog2(MAX_HOLD+1), clears on every new grant and increments each GRANT cycle. When it reaches MAX_HOLD-1 and any other req bit is set, the next edge forces rotation to the next picked requester even if req[owner] is still high. If no other requester is pending, grant holds and counter saturates at MAX_HOLD-1.
- Not defined: no counter; an owner keeps the mux indefinitely while its req stays high.

## Structure
- Shared package mux3_arb_pkg: select-encoding constants (SEL_D0=2'b00, SEL_D1=2'b01, SEL_I2=2'b10, SEL_NONE=2'b00), state encoding (ST_IDLE, ST_GRANT), requester count constant (3).
- One combinational sub-module rr_pick3: inputs req[2:0], ptr[1:0], mask[2:0] (excludes releasing owner); outputs found and winner index[1:0].
- Top holds state register, ptr, optional counter, and output registers.

## Test plan
- Reset: rst_n=0 with req=111 for 2 cycles -> gnt=000, sel=00, busy=0; release reset -> next edge gnt=001, sel=00.
- Single requester: req=100 from IDLE -> one cycle later gnt=100, sel_s1=1, sel_s0=0; req=000 -> next edge gnt=000, busy=0.
- Round-robin: req=111 held, each owner drops its bit one cycle then reasserts -> grant order 001, 010, 100, 001 with no idle cycle between.
- Back-to-back handoff: owner 1 holding, req=101 sampled (bit 1 low) -> next edge gnt=100, sel=10 directly.
- Timeout (MUX3_ARB_TIMEOUT_EN, MAX_HOLD=4): req=011 held constant -> gnt=001 for 4 cycles, then 010 for 4 cycles, alternating; with req=001 only -> gnt=001 indefinitely.
- Mid-grant reset: owner 2 granted, rst_n=0 one edge -> gnt=000, sel=00, ptr=0; with req=110 after reset -> gnt=010.
